// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide sequencer.
package mdu_pkg;

    localparam int          ITER_COUNT = 32;
    localparam logic [31:0] DBZ_LO     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP_A,
        S_PREP_B,
        S_ITER,
        S_FIX_LO,
        S_FIX_HI,
        S_DONE
    } mdu_state_e;

endpackage

// File: rtl/addsub32.sv
// 32-bit adder/subtracter: sum = a + b, or a - b when sub is set.
module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum
);

    assign sum = a + (sub ? ~b : b) + {31'b0, sub};

endmodule

// File: rtl/mdu_seq.sv
// Iterative mult/multu/div/divu sequencer sharing one addsub32.
// Optional MDU_DBZ_FAST_EN: divide-by-zero skips the iteration states.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             ready,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    if (WIDTH != 32) begin : g_width_check
        $error("mdu_seq supports WIDTH == 32 only");
    end

    mdu_state_e  state, state_n;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] acc_hi, acc_lo, dvs, a_raw;
    logic        neg_lo, neg_hi, dbz_q;

    logic [31:0] add_a, add_b, sum;
    logic        add_sub;
    logic [31:0] rem_sh;
    logic        carry, borrow, div_ok;
    logic [32:0] mul_hi33;
    logic        is_div, is_sgn, sa, sb;
    logic        accept, commit;
    logic [31:0] hi_n, lo_n;

    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];
    assign sa     = is_sgn & acc_lo[31];
    assign sb     = is_sgn & dvs[31];
    assign rem_sh = {acc_hi[30:0], acc_lo[31]};
    assign accept = (state == S_IDLE) & start & ~cancel;

    addsub32 u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (sum)
    );

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        unique case (state)
            S_PREP_A: begin
                add_b   = acc_lo;
                add_sub = 1'b1;
            end
            S_PREP_B: begin
                add_b   = dvs;
                add_sub = 1'b1;
            end
            S_ITER: begin
                add_a   = is_div ? rem_sh : acc_hi;
                add_b   = dvs;
                add_sub = is_div;
            end
            S_FIX_LO: begin
                add_b   = acc_lo;
                add_sub = 1'b1;
            end
            S_FIX_HI: begin
                if (is_div) begin
                    add_b   = acc_hi;
                    add_sub = 1'b1;
                end else begin
                    // Upper half of a 64-bit negate: carry in only if LO was zero
                    add_a = ~acc_hi;
                    add_b = {31'b0, (acc_lo == 32'd0)};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        carry  = (add_a[31] & add_b[31])
               | ((add_a[31] | add_b[31]) & ~sum[31]);
        borrow = (~add_a[31] & add_b[31])
               | ((~add_a[31] | add_b[31]) & sum[31]);
        // A bit shifted out of the remainder guarantees the subtract fits
        div_ok   = acc_hi[31] | ~borrow;
        mul_hi33 = acc_lo[0] ? {carry, sum} : {1'b0, acc_hi};
    end

    always_comb begin
        hi_n = neg_hi ? sum : acc_hi;
        lo_n = acc_lo;
        if (dbz_q) begin
            hi_n = a_raw;
            lo_n = DBZ_LO;
        end
    end

    always_comb begin
        commit = (state == S_FIX_HI) & ~cancel;
`ifdef MDU_DBZ_FAST_EN
        if ((state == S_PREP_A) && dbz_q && !cancel) begin
            commit = 1'b1;
        end
`endif
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (start) state_n = S_PREP_A;
`ifdef MDU_DBZ_FAST_EN
            S_PREP_A: state_n = dbz_q ? S_DONE : S_PREP_B;
`else
            S_PREP_A: state_n = S_PREP_B;
`endif
            S_PREP_B: state_n = S_ITER;
            S_ITER:   if (cnt == 5'd0) state_n = S_FIX_LO;
            S_FIX_LO: state_n = S_FIX_HI;
            S_FIX_HI: state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
        if (cancel) begin
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            dvs    <= '0;
            a_raw  <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        acc_hi <= '0;
                        acc_lo <= a;
                        dvs    <= b;
                        a_raw  <= a;
                        dbz_q  <= op[1] & (b == 32'd0);
                    end
                end
                S_PREP_A: begin
                    neg_lo <= sa ^ sb;
                    neg_hi <= is_div ? sa : (sa ^ sb);
                    if (sa) acc_lo <= sum;
                end
                S_PREP_B: begin
                    if (sb) dvs <= sum;
                    cnt <= 5'(ITER_COUNT - 1);
                end
                S_ITER: begin
                    cnt <= cnt - 5'd1;
                    if (is_div) begin
                        acc_hi <= div_ok ? sum : rem_sh;
                        acc_lo <= {acc_lo[30:0], div_ok};
                    end else begin
                        acc_hi <= mul_hi33[32:1];
                        acc_lo <= {mul_hi33[0], acc_lo[31:1]};
                    end
                end
                S_FIX_LO: begin
                    if (neg_lo) acc_lo <= sum;
                end
                S_FIX_HI: begin
                    if (neg_hi) acc_hi <= sum;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            dbz <= 1'b0;
        end else if (commit) begin
            hi  <= hi_n;
            lo  <= lo_n;
            dbz <= dbz_q;
        end else if (accept) begin
            dbz <= 1'b0;
        end
    end

    assign busy  = (state != S_IDLE);
    assign ready = (state == S_DONE);

endmodule
